apb_master_arbiter: RTL

Two-requester APB master that shares the I2C controller's APB slave port between a host-side requester (0) and a DMA/sequencer requester (1). It arbitrates round-robin, drives the APB SETUP/ACCESS protocol, waits on PREADY with a bounded timeout, and returns read data and error status to the granted requester. It sits directly in front of the I2C APB slave and is the only driver of its PSELx/PENABLE/PWRITE/PADDR/PWDATA inputs.

---
 rtl/apb_arb_pkg.sv | 20 ++
 rtl/rr_arbiter_2.sv | 28 ++
 rtl/apb_master_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
// Shared types for the two-requester APB master arbiter.
//   state_e    : transfer FSM states (IDLE, SETUP, ACCESS, RESP)
//   cnt_width(): width of a counter that must hold 0..timeout_cycles
// ---------------------------------------------------------------------------
package apb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   function automatic int cnt_width(input int timeout_cycles);
      return $clog2(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
// Combinational two-way round-robin pick.
//   valid0_i, valid1_i : request pending on requester 0 / 1
//   last_grant_i       : requester that owned the last completed transfer
//   winner_o           : selected requester index
//   any_valid_o        : at least one request pending
// A lone request wins outright; on a tie the requester that was not last
// granted wins.
// ---------------------------------------------------------------------------
module rr_arbiter_2 (
   input  logic valid0_i,
   input  logic valid1_i,
   input  logic last_grant_i,
   output logic winner_o,
   output logic any_valid_o
);

   always_comb begin
      any_valid_o = valid0_i | valid1_i;
      if (valid0_i && valid1_i) begin
         winner_o = ~last_grant_i;
      end else begin
         winner_o = valid1_i;
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
// Shares one APB slave port between requester 0 (host) and requester 1
// (DMA/sequencer). Round-robin arbitration, APB SETUP/ACCESS sequencing,
// bounded PREADY wait, per-port response registers.
//   PCLK, PRESETn            : clock, synchronous active-low reset
//   REQn_VALID/WRITE/ADDR/WDATA, REQn_READY : request channel per requester
//   RSPn_VALID/RDATA/ERR     : one-cycle response pulse, data/err held
//   PSELx/PENABLE/PWRITE/PADDR/PWDATA, PRDATA/PREADY/PSLVERR : APB master
//   BUSY, GRANT              : status; DBG_STATE exposes the FSM state
// Handshake: a request transfers on a cycle where REQn_VALID && REQn_READY;
// READY is only ever raised in IDLE, for the arbitration winner, and the
// requester must hold VALID and payload stable until it sees READY.
// ---------------------------------------------------------------------------
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              REQ0_VALID,
   input  logic              REQ0_WRITE,
   input  logic [ADDR_W-1:0] REQ0_ADDR,
   input  logic [DATA_W-1:0] REQ0_WDATA,
   output logic              REQ0_READY,
   input  logic              REQ1_VALID,
   input  logic              REQ1_WRITE,
   input  logic [ADDR_W-1:0] REQ1_ADDR,
   input  logic [DATA_W-1:0] REQ1_WDATA,
   output logic              REQ1_READY,
   output logic              RSP0_VALID,
   output logic [DATA_W-1:0] RSP0_RDATA,
   output logic              RSP0_ERR,
   output logic              RSP1_VALID,
   output logic [DATA_W-1:0] RSP1_RDATA,
   output logic              RSP1_ERR,
   output logic              PSELx,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR,
   output logic              BUSY,
   output logic              GRANT,
   output logic [1:0]        DBG_STATE
);

   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic                grant_q, grant_d;
   logic                last_grant_q, last_grant_d;
   logic [DATA_W-1:0]   rsp0_rdata_q, rsp0_rdata_d, rsp1_rdata_q, rsp1_rdata_d;
   logic                rsp0_err_q, rsp0_err_d, rsp1_err_q, rsp1_err_d;
   logic                winner, any_valid;
   logic                done;
   logic [DATA_W-1:0]   cap_rdata;
   logic                cap_err;

   rr_arbiter_2 u_arb (
      .valid0_i     (REQ0_VALID),
      .valid1_i     (REQ1_VALID),
      .last_grant_i (last_grant_q),
      .winner_o     (winner),
      .any_valid_o  (any_valid)
   );

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      pwrite_d     = pwrite_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      rsp0_rdata_d = rsp0_rdata_q;
      rsp1_rdata_d = rsp1_rdata_q;
      rsp0_err_d   = rsp0_err_q;
      rsp1_err_d   = rsp1_err_q;
      done         = 1'b0;
      cap_rdata    = '0;
      cap_err      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               pwrite_d = winner ? REQ1_WRITE : REQ0_WRITE;
               paddr_d  = winner ? REQ1_ADDR  : REQ0_ADDR;
               pwdata_d = winner ? REQ1_WDATA : REQ0_WDATA;
               grant_d  = winner;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            wait_cnt_d = '0;
            state_d    = ST_ACCESS;
         end
         ST_ACCESS: begin
            // PREADY on the last allowed cycle is a normal completion.
            if (PREADY) begin
               done      = 1'b1;
               cap_rdata = pwrite_q ? '0 : PRDATA;
               cap_err   = PSLVERR;
            end else if (wait_cnt_q == LAST_WAIT) begin
               done      = 1'b1;
               cap_err   = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
            if (done) begin
               state_d = ST_RESP;
               if (grant_q) begin
                  rsp1_rdata_d = cap_rdata;
                  rsp1_err_d   = cap_err;
               end else begin
                  rsp0_rdata_d = cap_rdata;
                  rsp0_err_d   = cap_err;
               end
            end
         end
         ST_RESP: begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q      <= ST_IDLE;
         wait_cnt_q   <= '0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         rsp0_rdata_q <= '0;
         rsp1_rdata_q <= '0;
         rsp0_err_q   <= 1'b0;
         rsp1_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         rsp0_rdata_q <= rsp0_rdata_d;
         rsp1_rdata_q <= rsp1_rdata_d;
         rsp0_err_q   <= rsp0_err_d;
         rsp1_err_q   <= rsp1_err_d;
      end
   end

   // READY is masked while reset is asserted: the FSM will not take the
   // request on that edge, so advertising acceptance would lose it.
   assign REQ0_READY = PRESETn && (state_q == ST_IDLE) && !winner && REQ0_VALID;
   assign REQ1_READY = PRESETn && (state_q == ST_IDLE) &&  winner && REQ1_VALID;

   assign PSELx      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign PENABLE    = (state_q == ST_ACCESS);
   assign PWRITE     = pwrite_q;
   assign PADDR      = paddr_q;
   assign PWDATA     = pwdata_q;
   assign RSP0_VALID = (state_q == ST_RESP) && !grant_q;
   assign RSP1_VALID = (state_q == ST_RESP) &&  grant_q;
   assign RSP0_RDATA = rsp0_rdata_q;
   assign RSP1_RDATA = rsp1_rdata_q;
   assign RSP0_ERR   = rsp0_err_q;
   assign RSP1_ERR   = rsp1_err_q;
   assign BUSY       = (state_q != ST_IDLE);
   assign GRANT      = grant_q;
   assign DBG_STATE  = state_q;

endmodule
